// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: {remainder, quotient} from signed or unsigned operands.
// WIDTH+1 edges from accept to ready_o; ready_o/result_o hold while start_i stays high, annul_i aborts.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dz_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d, busy_q, busy_d, dz_q, dz_d;

  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     rem_nx, quo_nx, rem_fix, quo_fix, a_abs, b_abs;

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign dz_o     = dz_q;

  always_comb begin
    // rem_q < divisor always holds, so bit WIDTH of diff is a clean borrow flag
    diff    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_nx  = diff[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : diff[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    quo_fix = qneg_q ? -quo_nx : quo_nx;
    rem_fix = rneg_q ? -rem_nx : rem_nx;
    a_abs   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    b_abs   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIVZERO;
          end else begin
            dvd_d   = a_abs;
            dvs_d   = b_abs;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            qneg_d  = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            rneg_d  = signed_div_i & opdata1_i[WIDTH-1];
            busy_d  = 1'b1;
            state_d = BUSY;
          end
        end
      end
      DIVZERO: begin
        result_d = '0;
        dz_d     = 1'b1;
        ready_d  = 1'b1;
        state_d  = DONE;
      end
      BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
          dz_d     = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over completion and over a held start
    if (annul_i && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = '0;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      dz_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: 32-bit and 8-bit instances, vector table plus abort/reset sequences.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s32, st32, an32, rdy32, bsy32, dz32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        s8, st8, an8, rdy8, bsy8, dz8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
  } vec_t;

  vec_t        tbl[6];
  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32), .CNT_W(6)) u_d32 (
    .clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32),
    .busy_o(bsy32), .dz_o(dz32)
  );

  div_iter #(.WIDTH(8), .CNT_W(4)) u_d8 (
    .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8),
    .busy_o(bsy8), .dz_o(dz8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run32(input vec_t v);
    int          lat;
    int          nbusy;
    bit          got;
    logic [63:0] exp;
    @(negedge clk);
    s32 = v.sgn; a32 = v.a; b32 = v.b; st32 = 1'b1;
    exp_q.push_back(v.res);
    lat = 0; nbusy = 0; got = 0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bsy32) nbusy++;
      if (rdy32) got = 1;
    end
    exp = exp_q.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL d32_timeout actual=no_ready required=ready a=%h b=%h", v.a, v.b);
      @(negedge clk); st32 = 1'b0;
      repeat (2) @(posedge clk);
      return;
    end
    chk("d32_latency", 64'(lat), v.dz ? 64'd2 : 64'd33);
    chk("d32_result", res32, exp);
    chk("d32_dz", 64'(dz32), 64'(v.dz));
    chk("d32_busy_cycles", 64'(nbusy), v.dz ? 64'd0 : 64'd32);
    // operands scrambled while DONE must not disturb the held result
    @(negedge clk); a32 = ~a32; b32 = 32'd0;
    @(posedge clk); #1;
    chk("d32_hold_ready", 64'(rdy32), 64'd1);
    chk("d32_hold_result", res32, exp);
    @(negedge clk); st32 = 1'b0;
    @(posedge clk); #1;
    chk("d32_clear", {res32[62:0], rdy32} | 64'(dz32) | 64'(bsy32), 64'd0);
    @(posedge clk);
  endtask

  task automatic abort32(input bit use_rst);
    bit seen;
    @(negedge clk);
    s32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy_after_accept", 64'(bsy32), 64'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    st32 = 1'b0;
    if (use_rst) rst = 1'b1; else an32 = 1'b1;
    @(posedge clk); #1;
    chk(use_rst ? "rst_mid_busy" : "annul_mid_busy", 64'(bsy32), 64'd0);
    chk(use_rst ? "rst_mid_out" : "annul_mid_out", res32 | 64'(rdy32) | 64'(dz32), 64'd0);
    @(negedge clk); rst = 1'b0; an32 = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy32 || bsy32) seen = 1;
    end
    chk("abort_no_ready", 64'(seen), 64'd0);
    run32('{1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 1'b0});
  endtask

  task automatic run8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] res);
    int          lat;
    int          nbusy;
    bit          got;
    logic [15:0] exp;
    @(negedge clk);
    s8 = sgn; a8 = a; b8 = b; st8 = 1'b1;
    exp8_q.push_back(res);
    lat = 0; nbusy = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bsy8) nbusy++;
      if (rdy8) got = 1;
    end
    exp = exp8_q.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL d8_timeout actual=no_ready required=ready a=%h b=%h", a, b);
    end else begin
      chk("d8_latency", 64'(lat), 64'd9);
      chk("d8_result", 64'(res8), 64'(exp));
      chk("d8_busy_cycles", 64'(nbusy), 64'd8);
      chk("d8_dz", 64'(dz8), 64'd0);
    end
    @(negedge clk); st8 = 1'b0;
    @(posedge clk); #1;
    chk("d8_clear", 64'(res8) | 64'(rdy8), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    s32 = 0; st32 = 0; an32 = 0; a32 = 0; b32 = 0;
    s8 = 0; st8 = 0; an8 = 0; a8 = 0; b8 = 0;

    tbl[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},         1'b0};
    tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},   1'b0};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},   1'b0};
    tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000},   1'b0};
    tbl[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF},   1'b0};
    tbl[5] = '{1'b0, 32'h00001234,   32'd0,        64'd0,                          1'b1};

    // reset applied with start requested: nothing may leave reset state
    st32 = 1'b1; a32 = 32'd5; b32 = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out32", res32 | 64'(rdy32) | 64'(bsy32) | 64'(dz32), 64'd0);
    chk("reset_out8", 64'(res8) | 64'(rdy8) | 64'(bsy8) | 64'(dz8), 64'd0);
    @(negedge clk); rst = 1'b0; st32 = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 6; i++) run32(tbl[i]);

    // annul held together with start in IDLE blocks the accept
    @(negedge clk); a32 = 32'd50; b32 = 32'd5; st32 = 1'b1; an32 = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bsy32 || rdy32) seen = 1;
    end
    chk("annul_blocks_accept", 64'(seen), 64'd0);
    @(negedge clk); st32 = 1'b0; an32 = 1'b0;
    @(posedge clk);

    abort32(1'b0);
    abort32(1'b1);

    run8(1'b0, 8'd200, 8'd3, 16'h0242);
    run8(1'b1, 8'h80, 8'h03, 16'hFED6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle integer divider for the EX stage. Serves DIV/DIVU, with the result written to HI/LO.
- Iterative radix-2 trial-subtraction core using a start/ready handshake and an annul input.
- Runs alongside the ALU. EX holds stallreq high while the divide is in flight.
- Unlike the fixed 32-bit multi-cycle MADD/MSUB path, operand width is generic. Adds busy and divide-by-zero status.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
- opdata1_i  input  WIDTH  dividend; sampled at accept
- opdata2_i  input  WIDTH  divisor; sampled at accept
- start_i  input  1  request; must stay high until ready_o seen
- annul_i  input  1  abort (flush/exception); overrides start_i
- result_o  output  2*WIDTH  {remainder, quotient}, i.e. {HI, LO}
- ready_o  output  1  result valid
- busy_o  output  1  iteration in progress
- dz_o  output  1  divisor was zero (valid with ready_o)

Behaviour:
- State register is updated only on rising clk. rst=1 at an edge forces:
  - state IDLE
  - result_o=0, ready_o=0, busy_o=0, dz_o=0
  - counter=0
- rst overrides everything, including mid-iteration.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - Edge with start_i=1 and annul_i=0 is the accept edge.
  - If opdata2_i==0: go to DIVZERO.
  - Otherwise latch operands, clear the partial remainder, counter=0, go to BUSY.
  - Signed mode latches absolute values and records sign flags (dividend sign; dividend XOR divisor sign).
  - Any other case stays in IDLE with outputs at 0.
- DIVZERO: next edge sets result_o=0, dz_o=1, ready_o=1, then DONE.
- BUSY (busy_o=1), one iteration per edge:
  - diff = {partial_rem[WIDTH-1:0], next dividend MSB} - divisor, computed WIDTH+1 bits wide.
  - diff non-negative: remainder = diff, quotient bit = 1.
  - diff negative: shift only, quotient bit = 0.
  - counter increments each edge.
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th iteration): apply sign fix-up, load result_o, ready_o=1, busy_o=0, go to DONE.
- Sign fix-up (signed mode only):
  - Quotient negated if the XOR sign flag is set.
  - Remainder takes the dividend's sign.
  - Two's complement wrap applies: MIN_INT / -1 gives quotient MIN_INT, remainder 0, no trap.
- Latency: accept edge at cycle n gives ready_o=1 after edge n+WIDTH+1 (33 edges for WIDTH=32). Divide by zero gives ready_o=1 after edge n+2.
- DONE:
  - result_o, dz_o and ready_o hold while start_i=1.
  - First edge with start_i=0 returns to IDLE and clears result_o, ready_o and dz_o to 0.
  - No back-to-back accept from DONE; at least one IDLE cycle is required.
- annul_i=1 at any edge in DIVZERO, BUSY or DONE:
  - Go to IDLE; clear busy_o, ready_o, dz_o, result_o.
  - Partial results are discarded.
- annul_i takes priority over start_i and over completion on the same edge.
- Operand changes while not in IDLE are ignored.
- start_i dropping while in BUSY without annul: iteration continues to DONE, then returns to IDLE on the next edge.

Test Plan:
- WIDTH=32, unsigned, 100/7, start held -> ready_o rises exactly 33 edges after accept; result_o={0x00000002,0x0000000E}; busy_o high 32 cycles; dz_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o={0xFFFFFFFF,0xFFFFFFFD}. Signed 7/-2 -> {0x00000001,0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000,0x80000000}. Unsigned 0xFFFFFFFF / 1 -> {0,0xFFFFFFFF}.
- Divisor 0, dividend 0x1234 -> ready_o after 2 edges, dz_o=1, result_o=0; dropping start_i clears all outputs one edge later.
- Annul and reset mid-operation:
  - Accept 1000/3, annul_i pulsed at iteration 10 -> IDLE next edge, ready_o never asserts.
  - New 9/4 accepted afterwards -> {1,2}.
  - Repeat with rst pulsed instead of annul; same result.
- WIDTH=8, CNT_W=4 instance: unsigned 200/3 -> ready_o after 9 edges, result_o=16'h0242.
- WIDTH=8, CNT_W=4 instance: signed 0x80/0x03 -> {0xFE,0xD6}.
